// File: rtl/ser_shbuf_pkg.sv
// Shared definitions for the bit-serial shift operand buffer: default widths
// and the sequencer state encoding.
package ser_shbuf_pkg;

    localparam int SHB_W  = 32;
    localparam int SHB_SW = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SKIP = 2'd2,
        ST_EMIT = 2'd3
    } state_e;

endpackage

// File: rtl/ser_rotbuf.sv
// W-bit operand store: serial MSB-side load shifting right, or rotate right,
// both gated by an enable. Deliberately not reset; contents are always reloaded.
module ser_rotbuf
    import ser_shbuf_pkg::*;
#(
    parameter int W = SHB_W
) (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_load,
    input  logic i_din,
    output logic o_lsb
);

    logic [W-1:0] buf_q;
    logic [W-1:0] buf_d;

    // Next buffer value: load shifts the serial bit in at the MSB, otherwise rotate right
    always_comb begin
        if (i_load) begin
            buf_d = {i_din, buf_q[W-1:1]};
        end else begin
            buf_d = {buf_q[0], buf_q[W-1:1]};
        end
    end

    // Buffer register, updated only when enabled
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            buf_q <= buf_d;
        end
    end

    assign o_lsb = buf_q[0];

endmodule

// File: rtl/ser_shbuf.sv
// Serial operand buffer and sequencer ahead of the serial shifter: loads rs1 and
// the shift amount LSB-first, pre-rotates, then streams aligned bits with wrap flags.
module ser_shbuf
    import ser_shbuf_pkg::*;
#(
    parameter int W  = SHB_W,
    parameter int SW = SHB_SW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_start,
    input  logic          i_right,
    input  logic          i_signed,
    input  logic          i_rs1,
    input  logic          i_rs2,
    output logic          o_busy,
    output logic [SW-1:0] o_shamt,
    output logic          o_signbit,
    output logic          o_valid,
    output logic          o_d,
    output logic          o_wrap,
    output logic          o_done
);

    localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] shamt_q, shamt_d;
    logic          right_q, right_d;
    logic          signed_q, signed_d;
    logic          signbit_q, signbit_d;
    logic [SW-1:0] cnt_inc_s;
    logic          cnt_carry_s;
    logic [SW-1:0] skip_s;
    logic          wrap_s;
    logic          buf_en_s;
    logic          buf_load_s;
    logic          buf_lsb_s;

    assign {cnt_carry_s, cnt_inc_s} = {1'b0, cnt_q} + {{SW{1'b0}}, 1'b1};

    // Pre-rotation length and wrap flag; for a right shift n+shamt >= W is n > ~shamt
    always_comb begin
        if (right_q) begin
            skip_s = shamt_q;
            wrap_s = (cnt_q > ~shamt_q);
        end else begin
            skip_s = {SW{1'b0}} - shamt_q;
            wrap_s = (cnt_q < shamt_q);
        end
    end

    // Sequencer next-state, counter and capture logic; everything holds while i_en is low
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shamt_d    = shamt_q;
        right_d    = right_q;
        signed_d   = signed_q;
        signbit_d  = signbit_q;
        buf_en_s   = 1'b0;
        buf_load_s = 1'b0;
        if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d  = ST_LOAD;
                        right_d  = i_right;
                        signed_d = i_signed;
                        cnt_d    = {SW{1'b0}};
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    buf_en_s   = 1'b1;
                    buf_load_s = 1'b1;
                    cnt_d      = cnt_inc_s;
                    if (cnt_q < SW'(SW)) begin
                        shamt_d = {i_rs2, shamt_q[SW-1:1]};
                    end else begin
                        shamt_d = shamt_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        signbit_d = i_rs1 & right_q & signed_q;
                        cnt_d     = {SW{1'b0}};
                        if (skip_s == {SW{1'b0}}) begin
                            state_d = ST_EMIT;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SKIP: begin
                    buf_en_s = 1'b1;
                    if (cnt_inc_s == skip_s) begin
                        state_d = ST_EMIT;
                        cnt_d   = {SW{1'b0}};
                    end else begin
                        state_d = ST_SKIP;
                        cnt_d   = cnt_inc_s;
                    end
                end
                ST_EMIT: begin
                    buf_en_s = 1'b1;
                    cnt_d    = cnt_inc_s;
                    if (cnt_carry_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {SW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control registers with synchronous reset; a reset discards any partial operation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {SW{1'b0}};
            shamt_q   <= {SW{1'b0}};
            right_q   <= 1'b0;
            signed_q  <= 1'b0;
            signbit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shamt_q   <= shamt_d;
            right_q   <= right_d;
            signed_q  <= signed_d;
            signbit_q <= signbit_d;
        end
    end

    ser_rotbuf #(.W(W)) u_rotbuf (
        .i_clk  (i_clk),
        .i_en   (buf_en_s),
        .i_load (buf_load_s),
        .i_din  (i_rs1),
        .o_lsb  (buf_lsb_s)
    );

    // Outputs are decoded purely from registered state, never from inputs
    assign o_busy    = (state_q != ST_IDLE);
    assign o_valid   = (state_q == ST_EMIT);
    assign o_d       = o_valid & buf_lsb_s;
    assign o_wrap    = o_valid & wrap_s;
    assign o_done    = o_valid & (cnt_q == CNT_LAST);
    assign o_shamt   = shamt_q;
    assign o_signbit = signbit_q;

endmodule

// File: tb/tb_ser_shbuf.sv
// Self-checking bench for ser_shbuf: scoreboard of expected stream bits built
// from the operands, compared as the DUT emits them.
module tb_ser_shbuf;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_start, i_right, i_signed, i_rs1, i_rs2;
    logic       o_busy, o_signbit, o_valid, o_d, o_wrap, o_done;
    logic [4:0] o_shamt;

    typedef struct {
        logic d;
        logic wrap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ser_shbuf dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_start  (i_start),
        .i_right  (i_right),
        .i_signed (i_signed),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .o_busy   (o_busy),
        .o_shamt  (o_shamt),
        .o_signbit(o_signbit),
        .o_valid  (o_valid),
        .o_d      (o_d),
        .o_wrap   (o_wrap),
        .o_done   (o_done)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_en = 1'b1; i_start = 1'b1; i_right = 1'b1; i_signed = 1'b1;
        i_rs1 = 1'b1; i_rs2 = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({o_busy, o_valid, o_d, o_wrap, o_done, o_signbit, o_shamt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {o_busy, o_valid, o_d, o_wrap, o_done, o_signbit, o_shamt});
        end
        i_rst = 1'b0; i_start = 1'b0;
        next_cycle();
    endtask

    // One complete operation; optional i_en gaps in LOAD, SKIP and EMIT, optional start held high
    task automatic run_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic right,
                          input logic sgn, input bit gaps, input bit start_hold, input string name);
        int   shamt, s, k, first_v, done_c, n, g1, g2, g3, exp_first, exp_done;
        bit   en;
        exp_t e;
        logic exp_sign;
        shamt = int'(rs2[4:0]);
        s     = right ? shamt : (W - shamt) % W;
        for (int i = 0; i < W; i++) begin
            if (right) begin
                e.d    = rs1[(shamt + i) % W];
                e.wrap = (i + shamt >= W);
            end else begin
                e.d    = rs1[(i - shamt + W) % W];
                e.wrap = (i < shamt);
            end
            sb_q.push_back(e);
        end
        exp_sign  = rs1[31] & sgn & right;
        exp_first = 33 + s + (gaps ? 6 : 0);
        exp_done  = 64 + s + (gaps ? 9 : 0);
        g1 = gaps ? int'($urandom_range(2, 28)) : -100;
        g2 = (gaps && s > 0) ? 36 + int'($urandom_range(0, s - 1)) : -100;
        g3 = gaps ? exp_first + int'($urandom_range(0, 28)) : -100;
        first_v = -1; done_c = -1; n = 0; k = 0;
        i_en = 1'b1; i_start = 1'b1; i_right = right; i_signed = sgn;
        next_cycle();
        i_start = start_hold;
        for (int c = 1; c < 200 && done_c < 0; c++) begin
            en = !((c >= g1 && c < g1 + 3) || (c >= g2 && c < g2 + 3) || (c >= g3 && c < g3 + 3));
            i_en  = en;
            i_rs1 = (k < W) ? rs1[k] : 1'($urandom());
            i_rs2 = (k < W) ? rs2[k] : 1'($urandom());
            @(negedge clk);
            if (o_valid && first_v < 0) first_v = c;
            if (o_valid && en) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s_extra_bit: got bit %0d expected none", name, n);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (o_d !== e.d) begin
                        errors++;
                        $display("FAIL %s_d[%0d]: got %b expected %b", name, n, o_d, e.d);
                    end
                    checks++;
                    if (o_wrap !== e.wrap) begin
                        errors++;
                        $display("FAIL %s_wrap[%0d]: got %b expected %b", name, n, o_wrap, e.wrap);
                    end
                end
                n++;
                if (o_done) done_c = c;
            end
            if (en && k < W) k++;
            next_cycle();
        end
        checks++;
        if (done_c != exp_done) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_c, exp_done);
        end
        checks++;
        if (first_v != exp_first) begin
            errors++;
            $display("FAIL %s_first_cycle: got %0d expected %0d", name, first_v, exp_first);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_bits: got %0d left expected 0", name, sb_q.size());
        end
        sb_q.delete();
        checks++;
        if (o_signbit !== exp_sign) begin
            errors++;
            $display("FAIL %s_signbit: got %b expected %b", name, o_signbit, exp_sign);
        end
        checks++;
        if (o_shamt !== rs2[4:0]) begin
            errors++;
            $display("FAIL %s_shamt: got %0d expected %0d", name, o_shamt, rs2[4:0]);
        end
        i_start = 1'b0; i_en = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_done: got %b expected 0", name, o_busy);
        end
        next_cycle();
    endtask

    task automatic test_right();
        run_op(32'h8000_0010, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, "right_logical");
        run_op(32'h8000_0010, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, "right_arith");
    endtask

    task automatic test_left();
        run_op(32'h0000_0003, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, "left");
        run_op(32'h8000_0001, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, "left_one");
    endtask

    task automatic test_zero_shamt();
        run_op(32'hA5A5_A5A5, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, "zero_right");
        run_op(32'hA5A5_A5A5, 32'hFFFF_FFE0, 1'b0, 1'b0, 1'b0, 1'b0, "zero_left");
    endtask

    task automatic test_enable_gaps();
        run_op(32'h8000_0010, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0, "gaps_right");
        run_op($urandom(), 32'd13, 1'b0, 1'b0, 1'b1, 1'b0, "gaps_left");
    endtask

    task automatic test_rst_mid();
        i_en = 1'b1; i_start = 1'b1; i_right = 1'b1; i_signed = 1'b1;
        next_cycle();
        i_start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            i_rs1 = 1'b1;
            i_rs2 = (c == 3 || c == 5) ? 1'b1 : 1'b0;
            next_cycle();
        end
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_busy, o_valid, o_d, o_wrap, o_done, o_signbit, o_shamt} !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b expected 0",
                     {o_busy, o_valid, o_d, o_wrap, o_done, o_signbit, o_shamt});
        end
        next_cycle();
        run_op(32'h1234_5678, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_op(32'hDEAD_BEEF, 32'd17, 1'b1, 1'b1, 1'b0, 1'b1, "start_held");
        run_op(32'h0F0F_0F0F, 32'd31, 1'b0, 1'b0, 1'b0, 1'b1, "start_held_left");
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_start = 1'b0; i_right = 1'b0; i_signed = 1'b0;
        i_rs1 = 1'b0; i_rs2 = 1'b0;
        test_reset();
        test_right();
        test_left();
        test_zero_shamt();
        test_enable_gaps();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_shbuf.md
Name: ser_shbuf

Overview:
- Bit-serial operand buffer and sequencer that sits directly upstream of the serial shifter stage.
- Captures rs1 data and the shift amount serially, LSB-first, over 32 cycles, then pre-rotates the stored word.
- Replays the word as a 32-bit stream already aligned for the requested shift direction.
- Emits a per-bit wrap flag so the downstream stage only chooses between the data bit and fill (zero or sign).

Parameters:
- W, 32, data word width in bits; must be a power of two.
- SW, 5, shift-amount width; equals log2(W).

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  clock enable; when low, all state (FSM, counters, buffer) holds and outputs keep their values
- i_start  in  1  start request; sampled only in IDLE
- i_right  in  1  1 = right shift, 0 = left shift; latched on accepted start
- i_signed  in  1  arithmetic right shift; latched on accepted start
- i_rs1  in  1  serial data bit, LSB-first, during LOAD
- i_rs2  in  1  serial shift-amount source bit, LSB-first, during LOAD
- o_busy  out  1  high in any state other than IDLE
- o_shamt  out  SW  captured shift amount (rs2[SW-1:0])
- o_signbit  out  1  captured rs1[W-1] AND latched i_signed AND latched i_right
- o_valid  out  1  high in EMIT; o_d and o_wrap are meaningful
- o_d  out  1  stream data bit
- o_wrap  out  1  high when the current stream bit must be replaced by fill
- o_done  out  1  one-cycle pulse on the last EMIT cycle

Behaviour:
- States: IDLE, LOAD, SKIP, EMIT. Counter cnt is SW bits; a carry bit marks wrap.
- Reset (synchronous, active-high): state = IDLE; cnt = 0; o_busy, o_valid, o_d, o_wrap, o_done = 0; o_shamt = 0; o_signbit = 0. The buffer register is not reset.
- Reset mid-operation: return to IDLE on the next edge and discard any partial load.
- IDLE:
  - i_start & i_en → LOAD; latch i_right and i_signed; cnt = 0.
  - i_start while busy is ignored; there is no queueing.
- LOAD (W cycles, k = 0..W-1):
  - buf shifts right with i_rs1 entering at the MSB, so after W cycles buf[k] = rs1 bit k.
  - When k < SW, i_rs2 is shifted into the shamt register.
  - On k = W-1: capture o_signbit from i_rs1; go to SKIP, or straight to EMIT if the skip count is 0.
- SKIP:
  - Skip count S = shamt for a right shift; S = (W - shamt) mod W for a left shift.
  - Rotate buf right by one bit per cycle for S cycles. o_valid stays 0.
  - Then go to EMIT with cnt = 0.
- EMIT (exactly W cycles, n = 0..W-1):
  - o_d = buf[0]; buf rotates right each cycle.
  - Stream content: right shift emits rs1[(shamt+n) mod W]; left shift emits rs1[(n-shamt) mod W].
  - o_wrap: right shift → 1 iff n+shamt ≥ W; left shift → 1 iff n < shamt.
  - o_done = 1 on n = W-1; next state IDLE.
- shamt = 0: SKIP is bypassed for both directions; o_wrap = 0 for all of EMIT.
- Latency with i_en held high: start accepted at cycle 0; first EMIT bit at cycle 1+W+S; o_done at cycle 2W+S.
- A start arriving in the same cycle that o_done is high is ignored. A new start is accepted the cycle after o_done.
- Deasserting i_en at any point freezes the sequence exactly. Resuming produces the identical bit stream.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, LOAD, SKIP, EMIT);
  - W and SW defaults.
- One natural sub-module, ser_rotbuf: a W-bit register with serial-in load and rotate-right, plus an enable input. The FSM, counter and wrap logic stay in ser_shbuf.

Test Plan:
- Right logical: rs1 = 0x80000010, rs2 = 4, signed = 0.
  - Expect SKIP of 4 cycles.
  - Stream bits 0..27 equal 0x08000001 bits 0..27; bit 27 = 1.
  - o_wrap high for n = 28..31; o_signbit = 0.
- Right arithmetic: same operands with signed = 1 → o_signbit = 1; stream and wrap identical to the logical case.
- Left: rs1 = 0x00000003, rs2 = 30.
  - Expect SKIP of 2 cycles.
  - o_wrap high for n = 0..29; o_d at n = 30, 31 equals 1, 1.
- shamt = 0, both directions, rs1 = 0xA5A5A5A5.
  - First EMIT bit at cycle 33; stream equals rs1 LSB-first.
  - o_wrap never high; o_done at cycle 64.
- Disruptions:
  - Toggle i_en low for 3 random cycles inside each of LOAD, SKIP and EMIT → identical stream, delayed by 9 cycles.
  - Assert i_rst during SKIP → IDLE next cycle with all outputs 0; a subsequent start works normally.
- Start during busy and start coincident with o_done → both ignored; o_busy falls the cycle after o_done.
